rtc_control_module: RTL

Sequencer for the DS1302 serial-access block `function_module`. After reset it disables write protect and loads the initial time. It then polls the seconds, minutes and hours registers every `POLL_CYCLES` clocks and presents them as BCD. Between polls it serves host time-set requests. It sits between the display/host logic and `function_module`, and is the sole driver of that block's command inputs.

---
 rtl/rtc_control_module.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rtc_control_module.sv
// rtc_control_module
// Command sequencer for the DS1302 serial-access block (function_module).
// After reset it clears write protect and loads INIT_* as the time. It then
// reads seconds/minutes/hours every POLL_CYCLES clocks and serves host
// time-set requests between polls.
//
// Ports
//   CLK, RSTn                      clock, synchronous active-low reset
//   set_req, set_sec/min/hour      host time-set request and BCD values
//   func_done_sig, read_data       completion pulse / read result from function_module
//   func_start_sig, words_addr,
//   write_data                     command to function_module (10 write, 01 read)
//   time_sec/min/hour, time_valid  last polled BCD time and its update pulse
//   set_ack                        pulse when a set sequence has completed
//   busy                           high whenever the sequencer is not idle
//   err                            pulse when a transaction times out
module rtc_control_module #(
    parameter int unsigned POLL_CYCLES = 50_000_000,
    parameter int unsigned TIMEOUT     = 4096,
    parameter logic [7:0]  INIT_SEC    = 8'h00,
    parameter logic [7:0]  INIT_MIN    = 8'h00,
    parameter logic [7:0]  INIT_HOUR   = 8'h12
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       set_req,
    input  logic [7:0] set_sec,
    input  logic [7:0] set_min,
    input  logic [7:0] set_hour,
    input  logic       func_done_sig,
    input  logic [7:0] read_data,
    output logic [1:0] func_start_sig,
    output logic [7:0] words_addr,
    output logic [7:0] write_data,
    output logic [7:0] time_sec,
    output logic [7:0] time_min,
    output logic [7:0] time_hour,
    output logic       time_valid,
    output logic       set_ack,
    output logic       busy,
    output logic       err
);
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b10;
    localparam logic [1:0] CMD_RD   = 2'b01;

    typedef enum logic [3:0] {
        S_INIT_WP, S_INIT_SEC, S_INIT_MIN, S_INIT_HOUR, S_IDLE,
        S_RD_SEC, S_RD_MIN, S_RD_HOUR, S_UPDATE,
        S_SET_WP, S_SET_SEC, S_SET_MIN, S_SET_HOUR, S_SET_DONE
    } state_t;

    state_t        state_reg, state_next, succ_state, cmd_state;
    logic [1:0]    start_reg, start_next, cmd_start;
    logic [7:0]    addr_reg, addr_next, cmd_addr;
    logic [7:0]    data_reg, data_next, cmd_data;
    logic          issued_reg, issued_next;
    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic [PW-1:0] poll_reg, poll_next;
    logic [7:0]    lat_sec_reg, lat_sec_next, lat_min_reg, lat_min_next, lat_hour_reg, lat_hour_next;
    logic [7:0]    shadow_sec_reg, shadow_sec_next, shadow_min_reg, shadow_min_next;
    logic [7:0]    tsec_reg, tsec_next, tmin_reg, tmin_next, thour_reg, thour_next;
    logic          time_valid_reg, time_valid_next, set_ack_reg, set_ack_next;
    logic          busy_reg, busy_next, err_reg, err_next;
    logic          in_init;

    assign in_init = (state_reg == S_INIT_WP) || (state_reg == S_INIT_SEC) ||
                     (state_reg == S_INIT_MIN) || (state_reg == S_INIT_HOUR);

    // Command belonging to a state. From IDLE the command of the state being
    // entered is issued on the same edge, so a burst starts without a dead cycle.
    assign cmd_state = (state_reg == S_IDLE) ? (set_req ? S_SET_WP : S_RD_SEC) : state_reg;

    always_comb begin
        cmd_start = CMD_IDLE;
        cmd_addr  = 8'h00;
        cmd_data  = 8'h00;
        case (cmd_state)
            S_INIT_WP, S_SET_WP: begin cmd_start = CMD_WR; cmd_addr = 8'h8E; end
            // Seconds bit 7 is clock-halt; it is always written as 0.
            S_INIT_SEC:  begin cmd_start = CMD_WR; cmd_addr = 8'h80; cmd_data = {1'b0, INIT_SEC[6:0]}; end
            S_INIT_MIN:  begin cmd_start = CMD_WR; cmd_addr = 8'h82; cmd_data = INIT_MIN; end
            S_INIT_HOUR: begin cmd_start = CMD_WR; cmd_addr = 8'h84; cmd_data = INIT_HOUR; end
            S_SET_SEC:   begin cmd_start = CMD_WR; cmd_addr = 8'h80; cmd_data = {1'b0, lat_sec_reg[6:0]}; end
            S_SET_MIN:   begin cmd_start = CMD_WR; cmd_addr = 8'h82; cmd_data = lat_min_reg; end
            S_SET_HOUR:  begin cmd_start = CMD_WR; cmd_addr = 8'h84; cmd_data = lat_hour_reg; end
            S_RD_SEC:    begin cmd_start = CMD_RD; cmd_addr = 8'h81; end
            S_RD_MIN:    begin cmd_start = CMD_RD; cmd_addr = 8'h83; end
            S_RD_HOUR:   begin cmd_start = CMD_RD; cmd_addr = 8'h85; end
            default: ;
        endcase
    end

    always_comb begin
        succ_state = S_IDLE;
        case (state_reg)
            S_INIT_WP:   succ_state = S_INIT_SEC;
            S_INIT_SEC:  succ_state = S_INIT_MIN;
            S_INIT_MIN:  succ_state = S_INIT_HOUR;
            S_RD_SEC:    succ_state = S_RD_MIN;
            S_RD_MIN:    succ_state = S_RD_HOUR;
            S_RD_HOUR:   succ_state = S_UPDATE;
            S_SET_WP:    succ_state = S_SET_SEC;
            S_SET_SEC:   succ_state = S_SET_MIN;
            S_SET_MIN:   succ_state = S_SET_HOUR;
            S_SET_HOUR:  succ_state = S_SET_DONE;
            default:     succ_state = S_IDLE;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        start_next      = start_reg;
        addr_next       = addr_reg;
        data_next       = data_reg;
        issued_next     = issued_reg;
        tcnt_next       = tcnt_reg;
        poll_next       = poll_reg;
        lat_sec_next    = lat_sec_reg;
        lat_min_next    = lat_min_reg;
        lat_hour_next   = lat_hour_reg;
        shadow_sec_next = shadow_sec_reg;
        shadow_min_next = shadow_min_reg;
        tsec_next       = tsec_reg;
        tmin_next       = tmin_reg;
        thour_next      = thour_reg;
        time_valid_next = 1'b0;
        set_ack_next    = 1'b0;
        err_next        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (set_req || poll_reg == '0) begin
                    state_next  = set_req ? S_SET_WP : S_RD_SEC;
                    start_next  = cmd_start;
                    addr_next   = cmd_addr;
                    data_next   = cmd_data;
                    issued_next = 1'b1;
                    tcnt_next   = '0;
                    if (set_req) begin
                        lat_sec_next  = set_sec;
                        lat_min_next  = set_min;
                        lat_hour_next = set_hour;
                    end
                end else begin
                    poll_next = poll_reg - PW'(1);
                end
            end
            S_UPDATE: begin
                poll_next  = POLL_RELOAD;
                state_next = S_IDLE;
            end
            S_SET_DONE: begin
                poll_next  = '0;  // next IDLE cycle starts a read-back
                state_next = S_IDLE;
            end
            default: begin
                if (!issued_reg) begin
                    start_next  = cmd_start;
                    addr_next   = cmd_addr;
                    data_next   = cmd_data;
                    issued_next = 1'b1;
                    tcnt_next   = '0;
                end else if (func_done_sig) begin
                    start_next  = CMD_IDLE;
                    issued_next = 1'b0;
                    state_next  = succ_state;
                    case (state_reg)
                        S_RD_SEC: shadow_sec_next = read_data;
                        S_RD_MIN: shadow_min_next = read_data;
                        // Hours go straight to the output together with the
                        // two shadows, so time_valid lands in the UPDATE cycle.
                        S_RD_HOUR: begin
                            tsec_next       = shadow_sec_reg;
                            tmin_next       = shadow_min_reg;
                            thour_next      = read_data;
                            time_valid_next = 1'b1;
                        end
                        S_SET_HOUR: set_ack_next = 1'b1;
                        default: ;
                    endcase
                end else if (tcnt_reg == TO_LAST) begin
                    start_next  = CMD_IDLE;
                    issued_next = 1'b0;
                    err_next    = 1'b1;
                    state_next  = in_init ? S_INIT_WP : S_IDLE;
                end else begin
                    tcnt_next = tcnt_reg + TW'(1);
                end
            end
        endcase
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_reg      <= S_INIT_WP;
            start_reg      <= CMD_IDLE;
            addr_reg       <= 8'h00;
            data_reg       <= 8'h00;
            issued_reg     <= 1'b0;
            tcnt_reg       <= '0;
            poll_reg       <= POLL_RELOAD;
            lat_sec_reg    <= 8'h00;
            lat_min_reg    <= 8'h00;
            lat_hour_reg   <= 8'h00;
            shadow_sec_reg <= 8'h00;
            shadow_min_reg <= 8'h00;
            tsec_reg       <= 8'h00;
            tmin_reg       <= 8'h00;
            thour_reg      <= 8'h00;
            time_valid_reg <= 1'b0;
            set_ack_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_reg      <= start_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            issued_reg     <= issued_next;
            tcnt_reg       <= tcnt_next;
            poll_reg       <= poll_next;
            lat_sec_reg    <= lat_sec_next;
            lat_min_reg    <= lat_min_next;
            lat_hour_reg   <= lat_hour_next;
            shadow_sec_reg <= shadow_sec_next;
            shadow_min_reg <= shadow_min_next;
            tsec_reg       <= tsec_next;
            tmin_reg       <= tmin_next;
            thour_reg      <= thour_next;
            time_valid_reg <= time_valid_next;
            set_ack_reg    <= set_ack_next;
            busy_reg       <= busy_next;
            err_reg        <= err_next;
        end
    end

    assign func_start_sig = start_reg;
    assign words_addr     = addr_reg;
    assign write_data     = data_reg;
    assign time_sec       = tsec_reg;
    assign time_min       = tmin_reg;
    assign time_hour      = thour_reg;
    assign time_valid     = time_valid_reg;
    assign set_ack        = set_ack_reg;
    assign busy           = busy_reg;
    assign err            = err_reg;
endmodule
